// File: rtl/piir_pkg.sv
// piir_pkg: shared definitions for the piir_cascade biquad filter.
//   state_t        - controller states (IDLE, MAC, WB, OUT)
//   IDX_*          - index field of a configuration address
//   sat_max/sat_min - saturation limits of a signed W-bit sample
package piir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        OUT  = 2'd3
    } state_t;

    localparam logic [3:0] IDX_B0  = 4'd0;
    localparam logic [3:0] IDX_B1  = 4'd1;
    localparam logic [3:0] IDX_B2  = 4'd2;
    localparam logic [3:0] IDX_A1  = 4'd3;
    localparam logic [3:0] IDX_A2  = 4'd4;
    localparam logic [3:0] IDX_X1  = 4'd5;
    localparam logic [3:0] IDX_X2  = 4'd6;
    localparam logic [3:0] IDX_Y1  = 4'd7;
    localparam logic [3:0] IDX_Y2  = 4'd8;
    localparam logic [3:0] IDX_CLR = 4'd15;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/piir_mac_unit.sv
// piir_mac_unit: single signed W x W multiplier feeding a 2W+3-bit
// accumulator, followed by round-half-up, shift back to Q1.(W-1) and
// saturation.
//   clk, rst    - clock, asynchronous active-high reset (clears acc)
//   en          - accumulate one term this cycle
//   first       - this term starts a section (acc restarts from zero)
//   neg         - subtract the product instead of adding it
//   coef, opnd  - multiplier inputs, signed Q1.(W-1)
//   y, clip     - rounded/saturated result of acc, and "result was clipped"
module piir_mac_unit
    import piir_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                first,
    input  logic                neg,
    input  logic signed [W-1:0] coef,
    input  logic signed [W-1:0] opnd,
    output logic signed [W-1:0] y,
    output logic                clip
);

    localparam int AccW = 2 * W + 3;
    localparam logic signed [AccW-1:0] HALF = AccW'(1) << (W - 2);
    localparam logic signed [AccW-1:0] MAXV = AccW'(sat_max(W));
    localparam logic signed [AccW-1:0] MINV = AccW'(sat_min(W));

    logic signed [2*W-1:0]  prod;
    logic signed [AccW-1:0] term_v;
    logic signed [AccW-1:0] acc;
    logic signed [AccW-1:0] rounded;
    logic signed [AccW-1:0] shifted;

    // Operands are sign-extended explicitly so the full 2W-bit product is kept.
    assign prod   = $signed({{W{coef[W-1]}}, coef}) * $signed({{W{opnd[W-1]}}, opnd});
    assign term_v = {{3{prod[2*W-1]}}, prod};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (en) begin
            acc <= (first ? '0 : acc) + (neg ? -term_v : term_v);
        end
    end

    assign rounded = acc + HALF;
    assign shifted = rounded >>> (W - 1);

    always_comb begin
        y    = shifted[W-1:0];
        clip = 1'b0;
        if (shifted > MAXV) begin
            y    = MAXV[W-1:0];
            clip = 1'b1;
        end else if (shifted < MINV) begin
            y    = MINV[W-1:0];
            clip = 1'b1;
        end
    end

endmodule

// File: rtl/piir_cascade.sv
// piir_cascade: NSEC cascaded direct-form-I biquads sharing one MAC unit.
// Each section takes 5 MAC cycles and 1 write-back cycle, so a result
// appears 6*NSEC cycles after the sample is accepted.
//   Clk1, Rst            - clock, asynchronous active-high reset
//   in_valid/in_ready    - sample input handshake, in_data = x(n)
//   out_valid/out_ready  - result handshake, out_data = y(n) of last section
//   cfg_we/cfg_ready     - config write, cfg_addr = {section, index}
//   ovf                  - sticky saturation flag
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and cfg_ready are high only in IDLE; out_valid and
// out_data stay stable until out_ready is seen. Config writes offered while
// cfg_ready is low are dropped.
module piir_cascade
    import piir_pkg::*;
#(
    parameter  int W    = 16,
    parameter  int NSEC = 2,
    localparam int AW   = $clog2(NSEC) + 4
) (
    input  logic          Clk1,
    input  logic          Rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    input  logic          cfg_we,
    output logic          cfg_ready,
    input  logic [AW-1:0] cfg_addr,
    input  logic [W-1:0]  cfg_data,
    output logic          ovf
);

    localparam int SW = (NSEC > 1) ? $clog2(NSEC) : 1;

    state_t          state;
    logic [SW-1:0]   sec;
    logic [2:0]      term;
    logic signed [W-1:0] x0;
    logic signed [W-1:0] b0 [NSEC];
    logic signed [W-1:0] b1 [NSEC];
    logic signed [W-1:0] b2 [NSEC];
    logic signed [W-1:0] a1 [NSEC];
    logic signed [W-1:0] a2 [NSEC];
    logic signed [W-1:0] x1 [NSEC];
    logic signed [W-1:0] x2 [NSEC];
    logic signed [W-1:0] y1 [NSEC];
    logic signed [W-1:0] y2 [NSEC];

    logic [3:0]      cfg_idx;
    logic [AW-1:0]   cfg_sec_full;
    logic [SW-1:0]   cfg_sec;
    logic            cfg_hit;

    logic signed [W-1:0] mac_coef;
    logic signed [W-1:0] mac_opnd;
    logic                mac_neg;
    logic signed [W-1:0] mac_y;
    logic                mac_clip;

    assign in_ready  = (state == IDLE);
    assign cfg_ready = (state == IDLE);

    // The section field is taken by shifting so NSEC=1 (empty field) works.
    assign cfg_idx      = cfg_addr[3:0];
    assign cfg_sec_full = cfg_addr >> 4;
    assign cfg_sec      = cfg_sec_full[SW-1:0];
    assign cfg_hit      = cfg_we && cfg_ready && (cfg_sec_full < AW'(NSEC));

    // Term order b0x0, b1x1, b2x2, -a1y1, -a2y2.
    always_comb begin
        mac_coef = '0;
        mac_opnd = '0;
        mac_neg  = 1'b0;
        case (term)
            3'd0: begin mac_coef = b0[sec]; mac_opnd = x0;      end
            3'd1: begin mac_coef = b1[sec]; mac_opnd = x1[sec]; end
            3'd2: begin mac_coef = b2[sec]; mac_opnd = x2[sec]; end
            3'd3: begin mac_coef = a1[sec]; mac_opnd = y1[sec]; mac_neg = 1'b1; end
            3'd4: begin mac_coef = a2[sec]; mac_opnd = y2[sec]; mac_neg = 1'b1; end
            default: ;
        endcase
    end

    piir_mac_unit #(.W(W)) u_mac (
        .clk   (Clk1),
        .rst   (Rst),
        .en    (state == MAC),
        .first (term == 3'd0),
        .neg   (mac_neg),
        .coef  (mac_coef),
        .opnd  (mac_opnd),
        .y     (mac_y),
        .clip  (mac_clip)
    );

    always_ff @(posedge Clk1 or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            sec       <= '0;
            term      <= '0;
            x0        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf       <= 1'b0;
            for (int i = 0; i < NSEC; i++) begin
                b0[i] <= '0; b1[i] <= '0; b2[i] <= '0; a1[i] <= '0; a2[i] <= '0;
                x1[i] <= '0; x2[i] <= '0; y1[i] <= '0; y2[i] <= '0;
            end
        end else begin
            // Config is applied on the same edge a sample may be accepted,
            // so that sample already computes with the new value.
            if (cfg_hit) begin
                case (cfg_idx)
                    IDX_B0: b0[cfg_sec] <= cfg_data;
                    IDX_B1: b1[cfg_sec] <= cfg_data;
                    IDX_B2: b2[cfg_sec] <= cfg_data;
                    IDX_A1: a1[cfg_sec] <= cfg_data;
                    IDX_A2: a2[cfg_sec] <= cfg_data;
                    IDX_X1: x1[cfg_sec] <= cfg_data;
                    IDX_X2: x2[cfg_sec] <= cfg_data;
                    IDX_Y1: y1[cfg_sec] <= cfg_data;
                    IDX_Y2: y2[cfg_sec] <= cfg_data;
                    IDX_CLR: begin
                        ovf <= 1'b0;
                        for (int i = 0; i < NSEC; i++) begin
                            x1[i] <= '0; x2[i] <= '0; y1[i] <= '0; y2[i] <= '0;
                        end
                    end
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x0    <= in_data;
                        sec   <= '0;
                        term  <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    term <= term + 3'd1;
                    if (term == 3'd4) begin
                        state <= WB;
                    end
                end
                WB: begin
                    x2[sec] <= x1[sec];
                    x1[sec] <= x0;
                    y2[sec] <= y1[sec];
                    y1[sec] <= mac_y;
                    x0      <= mac_y;
                    term    <= '0;
                    if (mac_clip) begin
                        ovf <= 1'b1;
                    end
                    if (sec == SW'(NSEC - 1)) begin
                        out_data  <= mac_y;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end else begin
                        sec   <= sec + 1'b1;
                        state <= MAC;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/piir_cascade.md
PIIR_CASCADE -- requirements
Module: piir_cascade

Interface
REQ-001 SHALL have parameter W, default 16, meaning sample/coefficient width (signed Q1.(W-1)).
REQ-002 SHALL have parameter NSEC, default 2, meaning number of cascaded biquad sections (1..8).
REQ-003 SHALL have parameter AW = clog2(NSEC)+4, meaning cfg address width (derived, not overridden).
REQ-004 SHALL have ports as below, clock and reset first; one clock, reset asynchronous and active-high:
- Clk1  in  1  clock.
- Rst  in  1  asynchronous active-high reset.
- in_valid  in  1  input sample offered.
- in_ready  out  1  block accepts a sample.
- in_data  in  W  input sample x(n).
- out_valid  out  1  output sample held.
- out_ready  in  1  consumer takes the output.
- out_data  out  W  output y(n) of the last section.
- cfg_we  in  1  config write strobe.
- cfg_ready  out  1  config write accepted this cycle.
- cfg_addr  in  AW  {section, index}.
- cfg_data  in  W  config write data.
- ovf  out  1  sticky saturation flag.

Function
REQ-005 SHALL compute per section s: y = b0*x0 + b1*x1 + b2*x2 - a1*y1 - a2*y2; section s input is section s-1 output.
REQ-006 SHALL use one time-multiplexed signed W x W multiplier, with a 2W+3-bit accumulator.
REQ-007 SHALL accumulate full 2W-bit products with no per-term rounding.
REQ-008 SHALL, at section end, add 2^(W-2), arithmetic-shift right by W-1, then saturate to [-2^(W-1), 2^(W-1)-1].
REQ-009 SHALL set ovf when any saturation clips; ovf stays set until clear (REQ-017) or reset.
REQ-010 SHALL use FSM states IDLE, MAC, WB, OUT.
REQ-011 SHALL, in IDLE, drive in_ready=1; on in_valid&in_ready, latch in_data as section-0 x0 and go to MAC with section=0, term=0.
REQ-012 SHALL perform one term per cycle in MAC, order b0x0, b1x1, b2x2, -a1y1, -a2y2; after term 4 go to WB.
REQ-013 SHALL, in WB (1 cycle), round/saturate, shift history (x2<=x1, x1<=x0, y2<=y1, y1<=y), and forward y as next section's x0.
REQ-014 SHALL, after WB, go to MAC for the next section, or to OUT after the last section.
REQ-015 SHALL latch out_data and assert out_valid in OUT exactly 6*NSEC cycles after the accepting edge (12 for NSEC=2).
REQ-016 SHALL hold out_valid and out_data stable with in_ready=0 until out_valid&out_ready, then return to IDLE; a sample may be accepted the cycle after.
REQ-017 SHALL map cfg_addr index as: 0..4 = b0, b1, b2, a1, a2; 5..8 = x1, x2, y1, y2 preload; 15 = clear all history and ovf (data ignored); other indices ignored.
REQ-018 SHALL ignore writes whose section field is >= NSEC.
REQ-019 SHALL drive cfg_ready=1 only in IDLE; cfg_we while cfg_ready=0 is dropped, not queued.
REQ-020 SHALL, if cfg_we and in_valid coincide in IDLE, apply the config write first and accept the sample; the sample uses the updated value in its computation.
REQ-021 SHALL leave coefficients and history unchanged by out_ready backpressure.

Reset
REQ-022 SHALL, on Rst, immediately force: state=IDLE, in_ready=1, cfg_ready=1, out_valid=0, out_data=0, ovf=0, accumulator=0, all coefficients and history=0.
REQ-023 SHALL, if Rst asserts mid-computation, abort the in-flight sample with no output produced.

Structure
REQ-024 SHALL place the FSM state enum, coefficient index constants (IDX_B0..IDX_Y2, IDX_CLR=15) and the saturation limit functions in shared package piir_pkg.
REQ-025 SHALL implement the multiply-accumulate-round-saturate datapath as sub-module piir_mac_unit; FSM, register file and handshakes stay in piir_cascade.

Verification (W=16, NSEC=2)
REQ-026 SHALL verify reset: Rst pulse mid-MAC -> out_valid=0, out_data=0x0000, ovf=0, in_ready=1 next cycle; no stale output.
REQ-027 SHALL verify gain: both sections b0=0x4000, all else 0; input 0x4000 -> out_data=0x1000, out_valid exactly 12 cycles after accept.
REQ-028 SHALL verify feedback: sec0 b0=0x4000, a1=0xC000; sec1 b0=0x4000; inputs 0x4000, 0, 0 -> outputs 0x1000, 0x0800, 0x0400.
REQ-029 SHALL verify saturation: sec0 b0=b1=b2=0x7FFF, x1=x2 preload 0x7FFF; sec1 b0=0x7FFF; input 0x7FFF -> sec0 clips to 0x7FFF, ovf=1; index-15 write clears ovf.
REQ-030 SHALL verify backpressure: out_ready=0 for 20 cycles -> out_data stable, in_ready=0, second in_valid not accepted; release -> second sample accepted the next cycle.
REQ-031 SHALL verify config collision: cfg_we during MAC -> cfg_ready=0, coefficient unchanged on readback of result; cfg_we+in_valid in IDLE -> new coefficient used.
